// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: picks one pending producer result per
// cycle and registers it onto the CDB for exactly one cycle.
module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 3,
    parameter int SRC_W   = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ID_W-1:0]   req_id,
    input  logic [NUM_REQ-1:0]        req_int,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      cdb_hold,
    output logic                      cdb_valid,
    output logic [ID_W-1:0]           cdb_id,
    output logic                      cdb_int,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [SRC_W-1:0]          cdb_src
);

    localparam int SLOTS = 1 << SRC_W;

    logic [SRC_W-1:0]  rr_ptr_reg;
    logic [SRC_W-1:0]  rr_ptr_next;
    logic [SLOTS-1:0]  valid_pad;
    logic [SRC_W-1:0]  cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] rot_valid;
    logic              any_win;
    logic [SRC_W-1:0]  win_idx;
    logic [NUM_REQ-1:0] win;
    logic              grant_ok;
    logic              transfer;
    logic [ID_W-1:0]   mux_id;
    logic              mux_int;
    logic [DATA_W-1:0] mux_data;

    logic              cdb_valid_reg;
    logic [ID_W-1:0]   cdb_id_reg;
    logic              cdb_int_reg;
    logic [DATA_W-1:0] cdb_data_reg;
    logic [SRC_W-1:0]  cdb_src_reg;

    // Padding lets the rotated lookup index with a full SRC_W-bit value.
    assign valid_pad = SLOTS'(req_valid);

    // Candidate k is the producer k places after rr_ptr, wrapped at NUM_REQ.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rotate
        logic [SRC_W:0] sum;
        assign sum = {1'b0, rr_ptr_reg} + (SRC_W+1)'(gi);
        assign cand_idx[gi] = (sum >= (SRC_W+1)'(NUM_REQ)) ?
                              SRC_W'(sum - (SRC_W+1)'(NUM_REQ)) : sum[SRC_W-1:0];
        assign rot_valid[gi] = valid_pad[cand_idx[gi]];
    end

    // Descending scan so the candidate closest to rr_ptr is the one kept.
    always_comb begin
        any_win = 1'b0;
        win_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                any_win = 1'b1;
                win_idx = cand_idx[k];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_win
        assign win[gi] = any_win & (win_idx == SRC_W'(gi));
    end

    assign grant_ok  = ~cdb_hold & ~rst;
    assign req_ready = win & {NUM_REQ{grant_ok}};
    assign transfer  = any_win & grant_ok;

    // Explicit wrap keeps rr_ptr inside 0..NUM_REQ-1 for non-power-of-two counts.
    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (transfer) begin
            if (win_idx == SRC_W'(NUM_REQ - 1)) begin
                rr_ptr_next = '0;
            end else begin
                rr_ptr_next = win_idx + SRC_W'(1);
            end
        end
    end

    // AND-OR mux: payload of non-winning ports never reaches the bus.
    always_comb begin
        mux_id   = '0;
        mux_int  = 1'b0;
        mux_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            mux_id   = mux_id   | ({ID_W{win[i]}}   & req_id[i*ID_W +: ID_W]);
            mux_int  = mux_int  | (win[i]           & req_int[i]);
            mux_data = mux_data | ({DATA_W{win[i]}} & req_data[i*DATA_W +: DATA_W]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg    <= '0;
            cdb_valid_reg <= 1'b0;
            cdb_id_reg    <= '0;
            cdb_int_reg   <= 1'b0;
            cdb_data_reg  <= '0;
            cdb_src_reg   <= '0;
        end else begin
            rr_ptr_reg    <= rr_ptr_next;
            cdb_valid_reg <= transfer;
            cdb_id_reg    <= transfer ? mux_id   : '0;
            cdb_int_reg   <= transfer ? mux_int  : 1'b0;
            cdb_data_reg  <= transfer ? mux_data : '0;
            cdb_src_reg   <= transfer ? win_idx  : '0;
        end
    end

    assign cdb_valid = cdb_valid_reg;
    assign cdb_id    = cdb_id_reg;
    assign cdb_int   = cdb_int_reg;
    assign cdb_data  = cdb_data_reg;
    assign cdb_src   = cdb_src_reg;

endmodule
